hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter FPU_LAT, default 4, legal range 2..15: number of cycles a non-pipelined float op occupies the FPU.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 idValid  in  1  the ID-stage instruction is real, not a bubble.
REQ-005 idRs, idRt  in  5 each  source registers of the ID instruction.
REQ-006 idFloat, idDW  in  1 each  ID instruction is float / double-word.
REQ-007 exRWrite  in  1  EX instruction writes a register.
REQ-008 exWBsrc  in  2  EX write-back source; 2'b01 = memory load.
REQ-009 exDstReg  in  5  EX destination register.
REQ-010 branchTaken  in  1  branch resolved taken in EX this cycle.
REQ-011 oPCWrite, oIFIDWrite  out  1 each  PC / IF-ID register load enables.
REQ-012 oIFIDFlush, oIDEXFlush  out  1 each  zero IF-ID / inject bubble into ID-EX at the next edge.
REQ-013 oDWPhase  out  1  DW half being issued into ID-EX: 0 = low word, 1 = high word.
REQ-014 oFpuBusy  out  1  FPU occupied.

Function
REQ-015 State SHALL be: dwPhase (1 bit), fpuCnt (4 bits). Outputs SHALL be combinational from state and inputs, giving same-cycle stalls.
REQ-016 Priority SHALL be: branch flush > load-use stall > FPU stall > DW split > normal issue.
REQ-017 Normal issue SHALL drive oPCWrite=1, oIFIDWrite=1, both flushes 0.
REQ-018 Branch flush: branchTaken=1 SHALL give oPCWrite=1, oIFIDWrite=1, oIFIDFlush=1, oIDEXFlush=1, and dwPhase<=0.
REQ-019 Load-use condition: dwPhase=0, idValid, exRWrite, exWBsrc=2'b01, exDstReg!=0, and exDstReg equals idRs or idRt.
REQ-020 On load-use, outputs SHALL be oPCWrite=0, oIFIDWrite=0, oIDEXFlush=1, oIFIDFlush=0, for exactly one cycle per hazard.
REQ-021 oFpuBusy SHALL equal (fpuCnt!=0).
REQ-022 FPU stall: idValid & idFloat & oFpuBusy & dwPhase=0 SHALL produce the same outputs as a load-use stall.
REQ-023 Final issue of a float instruction SHALL load fpuCnt<=FPU_LAT-1. Final issue means a non-stalled, non-flushed issue with a single-phase instruction or dwPhase=1.
REQ-024 Otherwise fpuCnt SHALL decrement while nonzero and saturate at 0. A branch flush SHALL NOT clear fpuCnt.
REQ-025 DW split: idValid & idDW & dwPhase=0, with no higher-priority event, SHALL give oPCWrite=0, oIFIDWrite=0, no flush, oDWPhase=0, and dwPhase<=1.
REQ-026 With dwPhase=1, outputs SHALL be normal issue, oDWPhase=1, and dwPhase<=0. Load-use and FPU checks SHALL be suppressed; a branch flush still applies.
REQ-027 Float busy with fpuCnt=1 SHALL still stall; the float instruction issues on the following cycle.

Reset
REQ-028 While rst=1, outputs SHALL be: oPCWrite=0, oIFIDWrite=0, oIFIDFlush=1, oIDEXFlush=1, oDWPhase=0, oFpuBusy=0.
REQ-029 rst=1 SHALL asynchronously clear dwPhase and fpuCnt, aborting any DW split or FPU occupancy mid-operation.
REQ-030 The first rising edge after rst falls SHALL follow normal rules from state IDLE (dwPhase=0, fpuCnt=0).

Configuration
REQ-031 With macro HAZ_DW_SPLIT_EN defined, DW split per REQ-025/026 SHALL be compiled in.
REQ-032 Without HAZ_DW_SPLIT_EN, DW instructions SHALL issue in one cycle as single-phase, dwPhase logic SHALL be absent, and oDWPhase SHALL be tied 0.

Verification
REQ-033 Load-use: EX lw with exDstReg=5, ID idRs=5 -> one cycle of oPCWrite=0, oIDEXFlush=1, then normal issue. Repeat with exDstReg=0 -> no stall.
REQ-034 FPU: FPU_LAT=4, float issue at cycle 0, next float in ID at cycle 1 -> stalls at cycles 1-3, issues at cycle 4. oFpuBusy=1 for cycles 1-3.
REQ-035 DW: idDW=1 -> cycle 0 oDWPhase=0 with PC held, cycle 1 oDWPhase=1 with PC advancing. With the macro undefined -> a single cycle with oDWPhase=0.
REQ-036 Simultaneous events: branchTaken=1 during load-use, or during dwPhase=1 -> both flushes=1, oPCWrite=1, dwPhase returns to 0.
REQ-037 Reset: assert rst mid-DW-split with fpuCnt=2 -> outputs immediately take REQ-028 values. After release, oFpuBusy=0 and a float instruction issues without stall.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: branch flush, load-use and FPU-occupancy stalls, and
// optional two-phase double-word issue (compiled in with HAZ_DW_SPLIT_EN).
module hazard_ctrl #(
    parameter int unsigned FPU_LAT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       idValid,
    input  logic [4:0] idRs,
    input  logic [4:0] idRt,
    input  logic       idFloat,
    input  logic       idDW,
    input  logic       exRWrite,
    input  logic [1:0] exWBsrc,
    input  logic [4:0] exDstReg,
    input  logic       branchTaken,
    output logic       oPCWrite,
    output logic       oIFIDWrite,
    output logic       oIFIDFlush,
    output logic       oIDEXFlush,
    output logic       oDWPhase,
    output logic       oFpuBusy
);

    localparam logic [3:0] FPU_LOAD = 4'(FPU_LAT - 1);
    localparam logic [1:0] WB_MEM   = 2'b01;

    typedef enum logic [2:0] {
        EV_ISSUE,
        EV_FLUSH,
        EV_LOAD_USE,
        EV_FPU,
        EV_DW_SPLIT
    } event_e;

    event_e     ev;
    logic [3:0] fpu_cnt_q, fpu_cnt_d;
    logic       fpu_busy;
    logic       load_use;
    logic       fpu_stall;
    logic       dw_split;
    logic       final_float_issue;
    logic       dw_phase;

`ifdef HAZ_DW_SPLIT_EN
    logic dw_phase_q, dw_phase_d;

    assign dw_phase = dw_phase_q;
    assign dw_split = !dw_phase_q && idValid && idDW;

    // Every path except the split itself returns to the low-word phase.
    always_comb begin
        dw_phase_d = (ev == EV_DW_SPLIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) dw_phase_q <= 1'b0;
        else     dw_phase_q <= dw_phase_d;
    end
`else
    logic unused_dw;

    assign unused_dw = idDW;
    assign dw_phase  = 1'b0;
    assign dw_split  = 1'b0;
`endif

    assign fpu_busy = (fpu_cnt_q != 4'd0);

    // The high-word phase is already committed, so its hazard checks are masked.
    assign load_use  = !dw_phase && idValid && exRWrite && (exWBsrc == WB_MEM) &&
                       (exDstReg != 5'd0) && ((exDstReg == idRs) || (exDstReg == idRt));
    assign fpu_stall = !dw_phase && idValid && idFloat && fpu_busy;

    always_comb begin
        ev = EV_ISSUE;
        if (branchTaken)    ev = EV_FLUSH;
        else if (load_use)  ev = EV_LOAD_USE;
        else if (fpu_stall) ev = EV_FPU;
        else if (dw_split)  ev = EV_DW_SPLIT;
    end

    always_comb begin
        oPCWrite   = 1'b1;
        oIFIDWrite = 1'b1;
        oIFIDFlush = 1'b0;
        oIDEXFlush = 1'b0;
        oDWPhase   = dw_phase;
        oFpuBusy   = fpu_busy;
        if (rst) begin
            oPCWrite   = 1'b0;
            oIFIDWrite = 1'b0;
            oIFIDFlush = 1'b1;
            oIDEXFlush = 1'b1;
            oDWPhase   = 1'b0;
            oFpuBusy   = 1'b0;
        end else begin
            case (ev)
                EV_FLUSH: begin
                    oIFIDFlush = 1'b1;
                    oIDEXFlush = 1'b1;
                end
                EV_LOAD_USE, EV_FPU: begin
                    oPCWrite   = 1'b0;
                    oIFIDWrite = 1'b0;
                    oIDEXFlush = 1'b1;
                end
                EV_DW_SPLIT: begin
                    oPCWrite   = 1'b0;
                    oIFIDWrite = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // A flushed or stalled float never occupies the FPU; only its last issued half does.
    assign final_float_issue = (ev == EV_ISSUE) && idValid && idFloat;

    always_comb begin
        fpu_cnt_d = 4'd0;
        if (final_float_issue) fpu_cnt_d = FPU_LOAD;
        else if (fpu_busy)     fpu_cnt_d = fpu_cnt_q - 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fpu_cnt_q <= 4'd0;
        else     fpu_cnt_q <= fpu_cnt_d;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; expected output vectors are hand-derived.
// Vector order: {oPCWrite, oIFIDWrite, oIFIDFlush, oIDEXFlush, oDWPhase, oFpuBusy}.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       idValid, idFloat, idDW, exRWrite, branchTaken;
    logic [4:0] idRs, idRt, exDstReg;
    logic [1:0] exWBsrc;
    logic       oPCWrite, oIFIDWrite, oIFIDFlush, oIDEXFlush, oDWPhase, oFpuBusy;

    int total = 0;
    int bad   = 0;

    hazard_ctrl #(.FPU_LAT(4)) dut (
        .clk(clk), .rst(rst), .idValid(idValid), .idRs(idRs), .idRt(idRt),
        .idFloat(idFloat), .idDW(idDW), .exRWrite(exRWrite), .exWBsrc(exWBsrc),
        .exDstReg(exDstReg), .branchTaken(branchTaken),
        .oPCWrite(oPCWrite), .oIFIDWrite(oIFIDWrite), .oIFIDFlush(oIFIDFlush),
        .oIDEXFlush(oIDEXFlush), .oDWPhase(oDWPhase), .oFpuBusy(oFpuBusy)
    );

    always #5 clk = ~clk;

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic fl, input logic dw);
        idValid = v; idRs = rs; idRt = rt; idFloat = fl; idDW = dw;
    endtask

    task automatic set_ex(input logic rw, input logic [1:0] src, input logic [4:0] dst,
                          input logic br);
        exRWrite = rw; exWBsrc = src; exDstReg = dst; branchTaken = br;
    endtask

    task automatic chk(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {oPCWrite, oIFIDWrite, oIFIDFlush, oIDEXFlush, oDWPhase, oFpuBusy};
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Inputs settle early in the cycle, outputs are sampled mid-cycle, then the edge.
    task automatic step(input string tag, input logic [5:0] exp);
        #2;
        chk(tag, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        set_ex(1'b0, 2'b00, 5'd0, 1'b0);
        step("reset_outputs", 6'b001100);
        rst = 1'b0;
        step("idle_issue", 6'b110000);

        // Load-use
        set_id(1'b1, 5'd5, 5'd7, 1'b0, 1'b0);
        set_ex(1'b1, 2'b01, 5'd5, 1'b0);
        step("load_use_rs", 6'b000100);
        set_ex(1'b0, 2'b00, 5'd0, 1'b0);
        step("after_load_use", 6'b110000);
        set_ex(1'b1, 2'b01, 5'd7, 1'b0);
        step("load_use_rt", 6'b000100);
        set_id(1'b1, 5'd0, 5'd3, 1'b0, 1'b0);
        set_ex(1'b1, 2'b01, 5'd0, 1'b0);
        step("load_dst_r0", 6'b110000);
        set_id(1'b1, 5'd5, 5'd0, 1'b0, 1'b0);
        set_ex(1'b1, 2'b00, 5'd5, 1'b0);
        step("alu_not_load", 6'b110000);
        set_id(1'b0, 5'd5, 5'd0, 1'b0, 1'b0);
        set_ex(1'b1, 2'b01, 5'd5, 1'b0);
        step("bubble_no_stall", 6'b110000);

        // FPU occupancy, FPU_LAT=4
        set_ex(1'b0, 2'b00, 5'd0, 1'b0);
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b0);
        step("fpu_issue0", 6'b110000);
        step("fpu_stall1", 6'b000101);
        step("fpu_stall2", 6'b000101);
        step("fpu_stall3_cnt1", 6'b000101);
        step("fpu_issue4", 6'b110000);
        set_id(1'b1, 5'd1, 5'd2, 1'b0, 1'b0);
        step("int_while_busy", 6'b110001);
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b0);
        set_ex(1'b0, 2'b00, 5'd0, 1'b1);
        step("branch_keeps_fpu", 6'b111101);
        set_ex(1'b0, 2'b00, 5'd0, 1'b0);
        step("fpu_cnt1_stall", 6'b000101);
        step("fpu_issue_after", 6'b110000);
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        step("drain3", 6'b110001);
        step("drain2", 6'b110001);
        step("drain1", 6'b110001);
        step("drain0", 6'b110000);

        // Branch beats load-use
        set_id(1'b1, 5'd9, 5'd0, 1'b0, 1'b0);
        set_ex(1'b1, 2'b01, 5'd9, 1'b1);
        step("branch_over_load", 6'b111100);
        set_ex(1'b0, 2'b00, 5'd0, 1'b0);

        // Double-word
        set_id(1'b1, 5'd4, 5'd6, 1'b0, 1'b1);
`ifdef HAZ_DW_SPLIT_EN
        step("dw_lo", 6'b000000);
        step("dw_hi", 6'b110010);
        step("dw_next_lo", 6'b000000);
        set_ex(1'b0, 2'b00, 5'd0, 1'b1);
        step("dw_hi_branch", 6'b111110);
        set_ex(1'b0, 2'b00, 5'd0, 1'b0);
        step("dw_after_branch", 6'b000000);
        set_ex(1'b1, 2'b01, 5'd4, 1'b0);
        step("dw_hi_masks_lu", 6'b110010);
        set_ex(1'b0, 2'b00, 5'd0, 1'b0);
`else
        step("dw_single", 6'b110000);
        step("dw_single2", 6'b110000);
        set_ex(1'b0, 2'b00, 5'd0, 1'b1);
        step("dw_branch", 6'b111100);
        set_ex(1'b0, 2'b00, 5'd0, 1'b0);
`endif

        // Reset mid-operation with fpuCnt=2
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b0);
        step("pre_rst_float", 6'b110000);
        set_id(1'b1, 5'd4, 5'd6, 1'b0, 1'b1);
`ifdef HAZ_DW_SPLIT_EN
        step("pre_rst_dw_lo", 6'b000001);
`else
        step("pre_rst_dw", 6'b110001);
`endif
        rst = 1'b1;
        #1;
        chk("async_rst", 6'b001100);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b0);
        step("post_rst_float", 6'b110000);
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        step("post_rst_busy", 6'b110001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
